// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_level buffer and any CSR wrapper
// that exposes its status.
package fifo_pkg;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic almost_full;
      logic almost_empty;
      logic full;
      logic empty;
   } fifo_status_t;

   // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the address.
   function automatic int level_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_level_chk.sv
// Static and run-time consistency checks for fifo_level; no logic, only assertions.
module fifo_level_chk
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 1
) (
   input logic                              clk_i,
   input logic                              rst_i,
   input logic [level_width(ADDR_WIDTH)-1:0] level_i,
   input logic                              full_i,
   input logic                              empty_i
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LW    = level_width(ADDR_WIDTH);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

   generate
      if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
         $error("fifo_level: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
      end
   endgenerate

   a_level_range : assert property (@(posedge clk_i) disable iff (rst_i) level_i <= DEPTH_LVL);
   a_full_empty  : assert property (@(posedge clk_i) disable iff (rst_i) !(full_i && empty_i));

endmodule

// File: rtl/fifo_level_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_level_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_r [2 ** ADDR_WIDTH];

   // Storage write port; contents are deliberately never reset or flushed
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_r[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy, threshold flags, sticky error flags,
// flush, and either first-word-fall-through or registered read data.
module fifo_level
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clear_i,
   input  logic                                wr_i,
   input  logic [DATA_WIDTH-1:0]               w_data_i,
   input  logic                                rd_i,
   output logic [DATA_WIDTH-1:0]               r_data_o,
   output logic                                empty_o,
   output logic                                full_o,
   output logic                                almost_empty_o,
   output logic                                almost_full_o,
   output logic [level_width(ADDR_WIDTH)-1:0]  level_o,
   output logic                                overflow_o,
   output logic                                underflow_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LW    = level_width(ADDR_WIDTH);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [LW-1:0]         level_r;
   logic [LW-1:0]         level_nxt_s;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic [DATA_WIDTH-1:0] head_s;
   fifo_status_t          status_s;

   fifo_level_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_acc_s),
      .waddr_i (wr_ptr_r),
      .wdata_i (w_data_i),
      .raddr_i (rd_ptr_r),
      .rdata_o (head_s)
   );

   // Flags come from the level register alone so they never glitch with rd_i/wr_i
   assign status_s.empty        = (level_r == {LW{1'b0}});
   assign status_s.full         = (level_r == DEPTH_LVL);
   assign status_s.almost_empty = (level_r <= AE_LVL);
   assign status_s.almost_full  = (level_r >= AF_LVL);
   assign status_s.overflow     = overflow_r;
   assign status_s.underflow    = underflow_r;

   assign empty_o        = status_s.empty;
   assign full_o         = status_s.full;
   assign almost_empty_o = status_s.almost_empty;
   assign almost_full_o  = status_s.almost_full;
   assign overflow_o     = status_s.overflow;
   assign underflow_o    = status_s.underflow;
   assign level_o        = level_r;

   // Accept decode and next occupancy; a full write rides on a same-cycle read
   always_comb begin
      rd_acc_s    = 1'b0;
      wr_acc_s    = 1'b0;
      level_nxt_s = level_r;
      if (!rst_i && !clear_i) begin
         rd_acc_s = rd_i && !status_s.empty;
         wr_acc_s = wr_i && (!status_s.full || rd_acc_s);
      end else begin
         rd_acc_s = 1'b0;
         wr_acc_s = 1'b0;
      end
      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_nxt_s = level_r + LW'(1);
         2'b01:   level_nxt_s = level_r - LW'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Pointers, occupancy and sticky error flags
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
         level_r     <= {LW{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
         end
         level_r <= level_nxt_s;
         if (wr_i && !wr_acc_s) begin
            overflow_r <= 1'b1;
         end
         if (rd_i && !rd_acc_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic seen_wr_r;

         // Storage is not reset, so mask the head to zero until something is written
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               seen_wr_r <= 1'b0;
            end else if (wr_acc_s) begin
               seen_wr_r <= 1'b1;
            end
         end

         assign r_data_o = seen_wr_r ? head_s : {DATA_WIDTH{1'b0}};
      end else begin : g_reg_rd
         logic [DATA_WIDTH-1:0] r_data_r;

         // Registered read data: loads on an accepted read, otherwise holds (also across flush)
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_data_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_acc_s) begin
               r_data_r <= head_s;
            end
         end

         assign r_data_o = r_data_r;
      end
   endgenerate

   fifo_level_chk #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_THRESH  (AF_THRESH),
      .AE_THRESH  (AE_THRESH)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (level_r),
      .full_i  (status_s.full),
      .empty_i (status_s.empty)
   );

endmodule
